// File: rtl/compound_acc_pkg.sv
// rtl/compound_acc_pkg.sv - opcode/state types shared by the compound-assignment engine
package compound_acc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASHL = 4'd10,
    OP_ASHR = 4'd11,
    OP_LOAD = 4'd12
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned OP_LAST_LEGAL = 12;

endpackage

// File: rtl/compound_acc_divider.sv
// rtl/compound_acc_divider.sv - WIDTH-cycle unsigned restoring divider
module compound_acc_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // One restoring step; quotient/remainder show the post-step values so the
  // final step's result is usable on the same edge that retires it.
  always_comb begin
    trial     = {rem_q, quo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    fits      = ~diff[WIDTH];
    remainder = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

  // Load operands on start, then advance one quotient bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      cnt   <= cnt - CW'(1);
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/compound_acc_unit.sv
// rtl/compound_acc_unit.sv - compound-assignment accumulator engine; DIV/MOD enabled by COMPOUND_ACC_DIV_EN
module compound_acc_unit
  import compound_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  state_e           state;
  state_e           state_n;
  cmd_op_e          op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             div_start;

  assign op = cmd_op_e'(cmd_op);

`ifdef COMPOUND_ACC_DIV_EN
  logic             div_busy;
  logic             div_done;
  logic             div_is_mod;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  compound_acc_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (acc),
    .divisor   (cmd_operand),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  // Single-cycle operators; anything unhandled here (illegal opcode, zero or
  // disabled divide) is rejected and leaves acc untouched.
  always_comb begin
    alu_res = acc;
    alu_err = 1'b0;
    case (op)
      OP_ADD:          alu_res = acc + cmd_operand;
      OP_SUB:          alu_res = acc - cmd_operand;
      OP_MUL:          alu_res = acc * cmd_operand;
      OP_AND:          alu_res = acc & cmd_operand;
      OP_OR:           alu_res = acc | cmd_operand;
      OP_XOR:          alu_res = acc ^ cmd_operand;
      OP_SHL, OP_ASHL: alu_res = acc << cmd_operand;
      OP_SHR:          alu_res = acc >> cmd_operand;
      OP_ASHR:         alu_res = $unsigned($signed(acc) >>> cmd_operand);
      OP_LOAD:         alu_res = cmd_operand;
      default:         alu_err = 1'b1;
    endcase
  end

  // Next-state and handshake outputs; cmd_ready depends on state only.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_n = ST_RESP;
`ifdef COMPOUND_ACC_DIV_EN
          if ((op == OP_DIV || op == OP_MOD) && cmd_operand != '0) begin
            div_start = 1'b1;
            state_n   = ST_DIVIDE;
          end
`endif
        end
      end
`ifdef COMPOUND_ACC_DIV_EN
      ST_DIVIDE: begin
        if (div_done) begin
          state_n = ST_RESP;
        end else if (!div_busy) begin
          state_n = ST_IDLE;
        end
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Accumulator and response registers; response fields only change on a
  // new result, so they hold steady throughout RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef COMPOUND_ACC_DIV_EN
      div_is_mod <= 1'b0;
`endif
    end else if (state == ST_IDLE && cmd_valid) begin
      if (div_start) begin
`ifdef COMPOUND_ACC_DIV_EN
        div_is_mod <= (op == OP_MOD);
`endif
      end else begin
        if (!alu_err) begin
          acc <= alu_res;
        end
        rsp_data <= alu_res;
        rsp_err  <= alu_err;
      end
    end
`ifdef COMPOUND_ACC_DIV_EN
    else if (state == ST_DIVIDE && div_done) begin
      acc      <= div_is_mod ? div_rem : div_quo;
      rsp_data <= div_is_mod ? div_rem : div_quo;
      rsp_err  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_compound_acc_unit.sv
// tb/tb_compound_acc_unit.sv - randomized and directed bench for compound_acc_unit
module tb_compound_acc_unit;

  localparam int W = 8;
`ifdef COMPOUND_ACC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = 4'd0;
  logic [W-1:0] cmd_operand = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [W-1:0] acc;

  int checks = 0;
  int failures = 0;
  int model_acc = 0;

  compound_acc_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .acc         (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what each compound assignment does to an unsigned W-bit value.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit err, output int lat);
    int m = 1 << W;
    int sa;
    err = 1'b0;
    res = a;
    lat = 1;
    case (op)
      0:  res = (a + b) % m;
      1:  res = (a - b + m) % m;
      2:  res = (a * b) % m;
      3, 4: begin
        if (!DIV_EN || b == 0) err = 1'b1;
        else begin
          res = (op == 3) ? a / b : a % b;
          lat = W + 1;
        end
      end
      5:  res = a & b;
      6:  res = a | b;
      7:  res = a ^ b;
      8, 10: res = (b >= W) ? 0 : (a << b) % m;
      9:  res = (b >= W) ? 0 : a >> b;
      11: begin
        sa = (a >= m / 2) ? a - m : a;
        if (b >= W) res = (sa < 0) ? m - 1 : 0;
        else res = (sa >>> b) & (m - 1);
      end
      12: res = b;
      default: err = 1'b1;
    endcase
    if (err) res = a;
  endfunction

  // Issue one command, check latency/result, hold rsp_ready low for `hold`
  // cycles, then complete the handshake. `spam` drives a LOAD while busy.
  task automatic do_op(input int op, input int opnd, input int hold,
                       input bit spam, output int got);
    int exp_res;
    bit exp_err;
    int exp_lat;
    int lat;
    model(op, model_acc, opnd, exp_res, exp_err, exp_lat);
    @(negedge clk);
    check($sformatf("cmd_ready_idle op%0d", op), cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_op      = op[3:0];
    cmd_operand = opnd[W-1:0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid   = spam;
    cmd_op      = 4'd12;
    cmd_operand = 8'h55;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check("cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    got = rsp_data;
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check($sformatf("rsp_data op%0d a=%0h b=%0h", op, model_acc, opnd), rsp_data, exp_res);
    check($sformatf("rsp_err op%0d", op), rsp_err, exp_err);
    check($sformatf("acc op%0d", op), acc, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp_res);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    model_acc = exp_res;
  endtask

  initial begin
    int got;
    int op;
    int opnd;

    repeat (3) @(negedge clk);
    check("reset_acc", acc, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;

    do_op(12, 8'h0F, 0, 1'b0, got); check("load_0f", got, 8'h0F);
    do_op(0, 8'hF5, 0, 1'b0, got);  check("add_wrap", got, 8'h04);
    do_op(1, 8'h05, 0, 1'b0, got);  check("sub_wrap", got, 8'hFF);
    do_op(2, 8'h03, 0, 1'b0, got);  check("mul_low", got, 8'hFD);
    do_op(7, 8'hF0, 0, 1'b0, got);  check("xor", got, 8'h0D);
    do_op(12, 8'h80, 0, 1'b0, got);
    do_op(11, 3, 0, 1'b0, got);     check("ashr_3", got, 8'hF0);
    do_op(12, 8'h80, 0, 1'b0, got);
    do_op(9, 3, 0, 1'b0, got);      check("shr_3", got, 8'h10);
    do_op(8, 9, 0, 1'b0, got);      check("shl_9", got, 8'h00);
    do_op(12, 8'h80, 0, 1'b0, got);
    do_op(11, 12, 0, 1'b0, got);    check("ashr_12", got, 8'hFF);
    do_op(12, 8'h64, 0, 1'b0, got);
    do_op(3, 7, 0, 1'b1, got);
`ifdef COMPOUND_ACC_DIV_EN
    check("div_100_7", got, 8'h0E);
`endif
    do_op(12, 8'h64, 0, 1'b0, got);
    do_op(4, 7, 5, 1'b0, got);
`ifdef COMPOUND_ACC_DIV_EN
    check("mod_100_7", got, 8'h02);
`endif
    do_op(3, 0, 0, 1'b0, got);
    do_op(13, 8'h21, 5, 1'b0, got);
    do_op(15, 8'h01, 0, 1'b0, got);

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 15);
      opnd = (op >= 8 && op <= 11 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                                              : $urandom_range(0, 255);
      if ((op == 3 || op == 4) && $urandom_range(0, 7) == 0) opnd = 0;
      do_op(op, opnd, $urandom_range(0, 2), $urandom_range(0, 1) == 1, got);
    end

    do_op(12, 8'h64, 0, 1'b0, got);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd3;
    cmd_operand = 8'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_acc", acc, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_cmd_ready", cmd_ready, 1);
    end
    check("abort_acc_after", acc, 0);
    do_op(0, 8'h11, 0, 1'b0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
